// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target-side SCL/SDA front end:
// stretch FSM encoding, synchronizer depth and default filter length.
package i2c_pkg;

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        HOLDING   = 2'd1,
        RELEASING = 2'd2
    } stretch_state_e;

    localparam int SYNC_STAGES        = 2;
    localparam int DEFAULT_FILTER_LEN = 3;
    localparam int FILTER_CNT_W       = 4;

endpackage

// File: rtl/i2c_line_filter.sv
// One bus line: two-flop synchronizer, FILTER_LEN-sample deglitcher and
// edge strobes that are high in the cycle before the filtered level flips.
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic rise_next,
    output logic fall_next
);

    logic [SYNC_STAGES-1:0]  sync_r;
    logic [FILTER_CNT_W-1:0] cnt_r;
    logic                    level_r;
    logic                    synced_s;
    logic                    flip_s;

    assign synced_s = sync_r[SYNC_STAGES-1];
    assign flip_s   = (synced_s != level_r) &&
                      (cnt_r == FILTER_CNT_W'(FILTER_LEN - 1));

    // Synchronizer shift chain; idle bus level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], line};
        end
    end

    // Deglitcher: any sample equal to the filtered level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= {FILTER_CNT_W{1'b0}};
            level_r <= 1'b1;
        end else if (synced_s == level_r) begin
            cnt_r   <= {FILTER_CNT_W{1'b0}};
        end else if (flip_s) begin
            cnt_r   <= {FILTER_CNT_W{1'b0}};
            level_r <= ~level_r;
        end else begin
            cnt_r   <= cnt_r + 4'd1;
        end
    end

    assign level     = level_r;
    assign rise_next = flip_s & ~level_r;
    assign fall_next = flip_s &  level_r;

endmodule

// File: rtl/i2c_scl_responder.sv
// I2C target-side bus front end: filtered levels, SCL edges, START/STOP and
// SCL clock stretching. Optional stretch timeout under I2C_STRETCH_TIMEOUT_EN.
module i2c_scl_responder
    import i2c_pkg::*;
#(
    parameter int          FILTER_LEN     = DEFAULT_FILTER_LEN,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic hold,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_o,
    output logic scl_level,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic scl_stretched,
    output logic stretch_timeout
);

    logic scl_level_s, sda_level_s;
    logic scl_rise_s, scl_fall_s, sda_rise_s, sda_fall_s;
    logic scl_steady_high_s;
    logic timeout_s, block_s;

    stretch_state_e state_r, state_next_s;
    logic scl_o_r, scl_stretched_r;
    logic scl_rise_r, scl_fall_r, start_det_r, stop_det_r;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk       (clk),
        .rst       (rst),
        .line      (scl_i),
        .level     (scl_level_s),
        .rise_next (scl_rise_s),
        .fall_next (scl_fall_s)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk       (clk),
        .rst       (rst),
        .line      (sda_i),
        .level     (sda_level_s),
        .rise_next (sda_rise_s),
        .fall_next (sda_fall_s)
    );

    // SCL high now and staying high: an SCL change in the same cycle voids START/STOP.
    assign scl_steady_high_s = scl_level_s & ~scl_fall_s;

    // Event pulses, masked while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_rise_r  <= 1'b0;
            scl_fall_r  <= 1'b0;
            start_det_r <= 1'b0;
            stop_det_r  <= 1'b0;
        end else begin
            scl_rise_r  <= en & scl_rise_s;
            scl_fall_r  <= en & scl_fall_s;
            start_det_r <= en & sda_fall_s & scl_steady_high_s;
            stop_det_r  <= en & sda_rise_s & scl_steady_high_s;
        end
    end

`ifdef I2C_STRETCH_TIMEOUT_EN
    logic [15:0] tmo_cnt_r;
    logic        block_r;
    logic        timeout_r;

    assign timeout_s = en && (state_r == HOLDING) &&
                       (tmo_cnt_r == (TIMEOUT_CYCLES - 16'd1));
    assign block_s   = block_r;

    // Stretch length counter; after a timeout, re-stretch waits for hold to drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= 16'd0;
            block_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            tmo_cnt_r <= (state_r == HOLDING) ? (tmo_cnt_r + 16'd1) : 16'd0;
            timeout_r <= timeout_s;
            if (timeout_s) begin
                block_r <= 1'b1;
            end else if (!hold) begin
                block_r <= 1'b0;
            end else begin
                block_r <= block_r;
            end
        end
    end

    assign stretch_timeout = timeout_r;
`else
    logic unused_timeout_s;

    assign unused_timeout_s = ^TIMEOUT_CYCLES;
    assign timeout_s        = 1'b0;
    assign block_s          = 1'b0;
    assign stretch_timeout  = 1'b0;
`endif

    // Stretch FSM next state; SCL is only ever pulled low once it is already low.
    always_comb begin
        state_next_s = state_r;
        if (!en) begin
            state_next_s = RELEASED;
        end else begin
            case (state_r)
                RELEASED: begin
                    if (hold && !scl_level_s && !block_s) begin
                        state_next_s = HOLDING;
                    end else begin
                        state_next_s = RELEASED;
                    end
                end
                HOLDING: begin
                    if (start_det_r || stop_det_r) begin
                        state_next_s = RELEASED;
                    end else if (timeout_s || !hold) begin
                        state_next_s = RELEASING;
                    end else begin
                        state_next_s = HOLDING;
                    end
                end
                RELEASING: begin
                    if (scl_rise_r) begin
                        state_next_s = RELEASED;
                    end else begin
                        state_next_s = RELEASING;
                    end
                end
                default: begin
                    state_next_s = RELEASED;
                end
            endcase
        end
    end

    // State and registered pad drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= RELEASED;
            scl_o_r         <= 1'b1;
            scl_stretched_r <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            scl_o_r         <= (state_next_s != HOLDING);
            scl_stretched_r <= (state_next_s == HOLDING);
        end
    end

    assign scl_o         = scl_o_r;
    assign scl_stretched = scl_stretched_r;
    assign scl_level     = scl_level_s;
    assign sda_level     = sda_level_s;
    assign scl_rise      = scl_rise_r;
    assign scl_fall      = scl_fall_r;
    assign start_det     = start_det_r;
    assign stop_det      = stop_det_r;

endmodule

// File: tb/tb_i2c_scl_responder.sv
// Self-checking bench for i2c_scl_responder: expected pulses (kind, cycle) are
// queued when stimulus is driven and matched against pulses seen on the outputs.
module tb_i2c_scl_responder;

`ifdef I2C_STRETCH_TIMEOUT_EN
    localparam logic [15:0] TB_TIMEOUT = 16'd20;
`else
    localparam logic [15:0] TB_TIMEOUT = 16'd50000;
`endif

    localparam int K_RISE = 0, K_FALL = 1, K_START = 2, K_STOP = 3, K_TMO = 4;

    logic clk = 1'b0, rst = 1'b1, en = 1'b1, hold = 1'b0;
    logic scl_ctrl = 1'b1, sda_ctrl = 1'b1;
    logic scl_pad;
    logic scl_o, scl_level, sda_level, scl_rise, scl_fall;
    logic start_det, stop_det, scl_stretched, stretch_timeout;

    typedef struct { int kind; int cyc; } ev_t;
    ev_t exp_q[$];
    ev_t obs_q[$];
    int  cyc = 0;
    int  checks = 0, failures = 0;

    // Open-drain bus: controller and DUT both pull low.
    assign scl_pad = scl_ctrl & scl_o;

    i2c_scl_responder #(.FILTER_LEN(3), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .hold            (hold),
        .scl_i           (scl_pad),
        .sda_i           (sda_ctrl),
        .scl_o           (scl_o),
        .scl_level       (scl_level),
        .sda_level       (sda_level),
        .scl_rise        (scl_rise),
        .scl_fall        (scl_fall),
        .start_det       (start_det),
        .stop_det        (stop_det),
        .scl_stretched   (scl_stretched),
        .stretch_timeout (stretch_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (scl_rise)        obs_q.push_back(ev_t'{K_RISE, cyc});
        if (scl_fall)        obs_q.push_back(ev_t'{K_FALL, cyc});
        if (start_det)       obs_q.push_back(ev_t'{K_START, cyc});
        if (stop_det)        obs_q.push_back(ev_t'{K_STOP, cyc});
        if (stretch_timeout) obs_q.push_back(ev_t'{K_TMO, cyc});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        tick(3);
        checks++; if (scl_o !== 1'b1) begin failures++; $display("FAIL rst_scl_o: got %b want 1", scl_o); end
        checks++; if (scl_level !== 1'b1 || sda_level !== 1'b1) begin failures++; $display("FAIL rst_levels: got %b%b want 11", scl_level, sda_level); end
        checks++; if (scl_stretched !== 1'b0) begin failures++; $display("FAIL rst_stretched: got %b want 0", scl_stretched); end
        checks++;
        if ({scl_rise, scl_fall, start_det, stop_det, stretch_timeout} !== 5'b00000) begin
            failures++;
            $display("FAIL rst_pulses: got %b want 00000", {scl_rise, scl_fall, start_det, stop_det, stretch_timeout});
        end
        rst = 1'b0;
        tick(6);
        checks++; if (scl_o !== 1'b1 || scl_level !== 1'b1) begin failures++; $display("FAIL idle_levels: scl_o %b scl_level %b want 1 1", scl_o, scl_level); end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL idle_pulses: got %0d pulses want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_glitch();
        ev_t e, o;
        scl_ctrl = 1'b0;
        tick(2);
        scl_ctrl = 1'b1;
        tick(10);
        checks++; if (obs_q.size() != 0 || scl_level !== 1'b1) begin failures++; $display("FAIL glitch_reject: pulses %0d scl_level %b want 0 1", obs_q.size(), scl_level); obs_q.delete(); end
        scl_ctrl = 1'b0;
        exp_q.push_back(ev_t'{K_FALL, cyc + 5});
        tick(3);
        scl_ctrl = 1'b1;
        exp_q.push_back(ev_t'{K_RISE, cyc + 5});
        tick(12);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL glitch_missing: got none want kind %0d at cycle %0d", e.kind, e.cyc); end
            else begin o = obs_q.pop_front(); if (o.kind !== e.kind || o.cyc !== e.cyc) begin failures++; $display("FAIL glitch_event: got kind %0d cycle %0d want kind %0d cycle %0d", o.kind, o.cyc, e.kind, e.cyc); end end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL glitch_extra: got %0d unexpected pulses want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_start_stop();
        ev_t e, o;
        sda_ctrl = 1'b0; exp_q.push_back(ev_t'{K_START, cyc + 5}); tick(10);
        sda_ctrl = 1'b1; exp_q.push_back(ev_t'{K_STOP, cyc + 5});  tick(10);
        scl_ctrl = 1'b0; exp_q.push_back(ev_t'{K_FALL, cyc + 5});  tick(10);
        sda_ctrl = 1'b0; tick(10);
        checks++; if (sda_level !== 1'b0) begin failures++; $display("FAIL sda_follow: got %b want 0", sda_level); end
        sda_ctrl = 1'b1; tick(10);
        scl_ctrl = 1'b1; exp_q.push_back(ev_t'{K_RISE, cyc + 5});  tick(10);
        scl_ctrl = 1'b0; sda_ctrl = 1'b0; exp_q.push_back(ev_t'{K_FALL, cyc + 5}); tick(10);
        scl_ctrl = 1'b1; sda_ctrl = 1'b1; exp_q.push_back(ev_t'{K_RISE, cyc + 5}); tick(10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL ss_missing: got none want kind %0d at cycle %0d", e.kind, e.cyc); end
            else begin o = obs_q.pop_front(); if (o.kind !== e.kind || o.cyc !== e.cyc) begin failures++; $display("FAIL ss_event: got kind %0d cycle %0d want kind %0d cycle %0d", o.kind, o.cyc, e.kind, e.cyc); end end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL ss_extra: got %0d unexpected pulses want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_stretch();
        ev_t e, o;
        int  p;
        hold = 1'b1;
        tick(8);
        checks++; if (scl_o !== 1'b1 || scl_stretched !== 1'b0) begin failures++; $display("FAIL hold_high: scl_o %b stretched %b want 1 0", scl_o, scl_stretched); end
        scl_ctrl = 1'b0; p = cyc;
        exp_q.push_back(ev_t'{K_FALL, p + 5});
        tick(5);
        checks++; if (scl_o !== 1'b1) begin failures++; $display("FAIL stretch_early: got scl_o %b want 1", scl_o); end
        tick(1);
        checks++; if (scl_o !== 1'b0 || scl_stretched !== 1'b1) begin failures++; $display("FAIL stretch_entry: scl_o %b stretched %b want 0 1", scl_o, scl_stretched); end
        scl_ctrl = 1'b1;
        tick(100);
        checks++; if (scl_o !== 1'b0 || scl_level !== 1'b0) begin failures++; $display("FAIL stretch_hold: scl_o %b scl_level %b want 0 0", scl_o, scl_level); end
        hold = 1'b0; p = cyc;
        tick(1);
        checks++; if (scl_o !== 1'b1 || scl_stretched !== 1'b0) begin failures++; $display("FAIL stretch_release: scl_o %b stretched %b want 1 0", scl_o, scl_stretched); end
        exp_q.push_back(ev_t'{K_RISE, p + 6});
        tick(12);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL stretch_missing: got none want kind %0d at cycle %0d", e.kind, e.cyc); end
            else begin o = obs_q.pop_front(); if (o.kind !== e.kind || o.cyc !== e.cyc) begin failures++; $display("FAIL stretch_event: got kind %0d cycle %0d want kind %0d cycle %0d", o.kind, o.cyc, e.kind, e.cyc); end end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL stretch_extra: got %0d unexpected pulses want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_en_mask();
        ev_t e, o;
        hold = 1'b1; scl_ctrl = 1'b0;
        exp_q.push_back(ev_t'{K_FALL, cyc + 5});
        tick(7);
        checks++; if (scl_o !== 1'b0) begin failures++; $display("FAIL en_setup: got scl_o %b want 0", scl_o); end
        scl_ctrl = 1'b1; en = 1'b0;
        tick(1);
        checks++; if (scl_o !== 1'b1 || scl_stretched !== 1'b0) begin failures++; $display("FAIL en_release: scl_o %b stretched %b want 1 0", scl_o, scl_stretched); end
        tick(8);
        sda_ctrl = 1'b0; tick(8);
        checks++; if (sda_level !== 1'b0 || scl_level !== 1'b1) begin failures++; $display("FAIL en_levels: sda %b scl %b want 0 1", sda_level, scl_level); end
        sda_ctrl = 1'b1; tick(8);
        hold = 1'b0; en = 1'b1;
        tick(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL en_missing: got none want kind %0d at cycle %0d", e.kind, e.cyc); end
            else begin o = obs_q.pop_front(); if (o.kind !== e.kind || o.cyc !== e.cyc) begin failures++; $display("FAIL en_event: got kind %0d cycle %0d want kind %0d cycle %0d", o.kind, o.cyc, e.kind, e.cyc); end end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL en_masked: got %0d pulses while disabled want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_mid();
        ev_t e, o;
        hold = 1'b1; scl_ctrl = 1'b0;
        exp_q.push_back(ev_t'{K_FALL, cyc + 5});
        tick(8);
        checks++; if (scl_o !== 1'b0) begin failures++; $display("FAIL rmid_setup: got scl_o %b want 0", scl_o); end
        scl_ctrl = 1'b1; hold = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (scl_o !== 1'b1 || scl_stretched !== 1'b0) begin failures++; $display("FAIL rmid_async: scl_o %b stretched %b want 1 0", scl_o, scl_stretched); end
        tick(2);
        rst = 1'b0;
        tick(8);
        checks++; if (scl_level !== 1'b1) begin failures++; $display("FAIL rmid_level: got %b want 1", scl_level); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL rmid_missing: got none want kind %0d at cycle %0d", e.kind, e.cyc); end
            else begin o = obs_q.pop_front(); if (o.kind !== e.kind || o.cyc !== e.cyc) begin failures++; $display("FAIL rmid_event: got kind %0d cycle %0d want kind %0d cycle %0d", o.kind, o.cyc, e.kind, e.cyc); end end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL rmid_extra: got %0d unexpected pulses want 0", obs_q.size()); obs_q.delete(); end
    endtask

`ifdef I2C_STRETCH_TIMEOUT_EN
    task automatic test_timeout();
        ev_t e, o;
        int  p;
        hold = 1'b1; scl_ctrl = 1'b0; p = cyc;
        exp_q.push_back(ev_t'{K_FALL, p + 5});
        exp_q.push_back(ev_t'{K_TMO, p + 26});
        tick(10);
        scl_ctrl = 1'b1;
        tick(15);
        checks++; if (scl_o !== 1'b0) begin failures++; $display("FAIL tmo_early: got scl_o %b want 0", scl_o); end
        tick(1);
        checks++; if (scl_o !== 1'b1 || stretch_timeout !== 1'b1) begin failures++; $display("FAIL tmo_fire: scl_o %b timeout %b want 1 1", scl_o, stretch_timeout); end
        exp_q.push_back(ev_t'{K_RISE, p + 31});
        tick(10);
        scl_ctrl = 1'b0;
        exp_q.push_back(ev_t'{K_FALL, cyc + 5});
        tick(8);
        checks++; if (scl_o !== 1'b1 || scl_stretched !== 1'b0) begin failures++; $display("FAIL tmo_block: scl_o %b stretched %b want 1 0", scl_o, scl_stretched); end
        hold = 1'b0; tick(2);
        hold = 1'b1; tick(3);
        checks++; if (scl_o !== 1'b0) begin failures++; $display("FAIL tmo_unblock: got scl_o %b want 0", scl_o); end
        hold = 1'b0; tick(2);
        scl_ctrl = 1'b1;
        exp_q.push_back(ev_t'{K_RISE, cyc + 5});
        tick(10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL tmo_missing: got none want kind %0d at cycle %0d", e.kind, e.cyc); end
            else begin o = obs_q.pop_front(); if (o.kind !== e.kind || o.cyc !== e.cyc) begin failures++; $display("FAIL tmo_event: got kind %0d cycle %0d want kind %0d cycle %0d", o.kind, o.cyc, e.kind, e.cyc); end end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL tmo_extra: got %0d unexpected pulses want 0", obs_q.size()); obs_q.delete(); end
    endtask
`endif

    initial begin
        test_reset();
        test_glitch();
        test_start_stop();
        test_stretch();
        test_en_mask();
        test_reset_mid();
`ifdef I2C_STRETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_scl_responder.md
Name: i2c_scl_responder

Overview:
- Target-side (responder) SCL/SDA front end, the counterpart of the controller's SCL generator.
- Synchronizes and deglitches the bus lines.
- Detects SCL edges and START/STOP conditions.
- Stretches SCL low when the target datapath raises `hold`.
- Sits between the open-drain pads and the target byte/bit FSM.

Parameters:
- FILTER_LEN, 3: consecutive equal synchronized samples required before a filtered line changes (1..15; 1 = no filtering).
- TIMEOUT_CYCLES, 16'd50000: maximum stretch length in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  block enable
- hold  in  1  target datapath not ready; request SCL stretch
- scl_i  in  1  SCL pad input
- sda_i  in  1  SDA pad input
- scl_o  out  1  SCL pad drive (0 = pull low, 1 = release)
- scl_level  out  1  filtered SCL
- sda_level  out  1  filtered SDA
- scl_rise  out  1  one-cycle pulse on filtered SCL 0->1
- scl_fall  out  1  one-cycle pulse on filtered SCL 1->0
- start_det  out  1  one-cycle pulse: SDA fell while SCL high (START or repeated START)
- stop_det  out  1  one-cycle pulse: SDA rose while SCL high
- scl_stretched  out  1  high while this block holds SCL low
- stretch_timeout  out  1  one-cycle pulse, optional feature only (tied 0 when compiled out)

Behaviour:
- Reset values (async, asserted immediately on rst):
  - scl_o=1, scl_level=1, sda_level=1, all sync flops=1.
  - Filter counters=0, all pulses=0, scl_stretched=0.
  - FSM in RELEASED.
- Synchronizer: 2 flops per line.
- Filter (per line):
  - Counter counts consecutive synchronized samples differing from the filtered level; any equal sample clears it.
  - On the FILTER_LEN-th consecutive differing sample, the filtered level flips and the counter clears.
- Edge and condition pulses:
  - Registered, asserted the cycle the filtered level changes.
  - Total latency from the pad change to the pulse is 2+FILTER_LEN cycles.
- START/STOP:
  - Evaluated on a filtered SDA change while filtered SCL is 1 (previous and current).
  - If SCL and SDA change in the same cycle, neither start_det nor stop_det fires.
- Stretch FSM states:
  - RELEASED: scl_o=1. On scl_fall with hold=1, or hold=1 while scl_level=0, go to HOLDING. hold while scl_level=1 has no effect; the block never pulls SCL low while it is high.
  - HOLDING: scl_o=0 (registered, driven the cycle after entry), scl_stretched=1. hold=0 -> RELEASING.
  - RELEASING: scl_o=1. Re-stretch is suppressed until scl_rise, then go to RELEASED. A hold re-asserted here takes effect at the next scl_fall.
- Filtered SCL seen in HOLDING is our own drive: no scl_rise is generated while holding, because the line stays low.
- en=0:
  - FSM forced to RELEASED, scl_o=1 within one cycle.
  - start_det/stop_det/scl_rise/scl_fall masked to 0.
  - Synchronizers and filters keep running so levels are valid when re-enabled.
- en falling mid-stretch releases SCL next cycle without any pulse.
- STOP or START detected while in HOLDING: release (go to RELEASED), because the bus transaction is over.

Optional Feature:
- Macro I2C_STRETCH_TIMEOUT_EN.
- Defined:
  - 16-bit counter runs in HOLDING and clears outside it.
  - When it reaches TIMEOUT_CYCLES-1: pulse stretch_timeout for one cycle, go to RELEASING regardless of hold, and block any re-stretch until hold has been seen 0.
- Undefined: no counter; stretch_timeout tied 0; stretch is unbounded.

Decomposition:
- Shared package i2c_pkg holds:
  - Stretch FSM state encoding (RELEASED=2'd0, HOLDING=2'd1, RELEASING=2'd2).
  - SYNC_STAGES=2.
  - Default FILTER_LEN.
- One natural sub-module, i2c_line_filter: synchronizer plus FILTER_LEN deglitcher plus edge pulse for one line, instantiated twice (SCL, SDA).

Test Plan:
- Reset/idle: rst pulse with lines high -> scl_o=1, scl_level=sda_level=1, no pulses; rst asserted mid-HOLDING -> scl_o=1 in the same timestep, without waiting for a clock edge.
- Glitch rejection, FILTER_LEN=3: SCL low for 2 cycles -> no scl_fall; SCL low for 3 cycles -> scl_fall exactly 5 cycles after the pad change.
- START/STOP: SDA 1->0 with SCL high -> one start_det; SDA 0->1 with SCL high -> one stop_det; SDA toggling while SCL low -> none.
- Stretch: hold=1 before scl_fall -> scl_o=0 the cycle after scl_fall, scl_stretched=1; hold=0 after 100 cycles -> scl_o=1 next cycle; SCL released by the controller -> single scl_rise.
- hold asserted while SCL high -> scl_o stays 1 until the next scl_fall; en=0 during HOLDING -> scl_o=1 next cycle and pulses masked.
- With I2C_STRETCH_TIMEOUT_EN, TIMEOUT_CYCLES=20: hold stuck at 1 -> stretch_timeout pulse 20 cycles after HOLDING entry, scl_o=1, no re-stretch until hold=0.
